// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO configuration shift chain: per-pad field offsets
// and the loader sequencing states.
package gpio_cfg_pkg;

    localparam int PAD_CTRL_BITS = 10;

    // Bit offsets inside one pad's control word.
    localparam int MGMT_EN = 0;
    localparam int OE_OVR  = 1;
    localparam int IE      = 2;
    localparam int OE      = 3;
    localparam int SCHMITT = 4;
    localparam int SLEW    = 5;
    localparam int PD      = 6;
    localparam int PU      = 7;
    localparam int DRIVE   = 8;
    localparam int DRIVE_W = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        HIGH   = 3'd2,
        LOAD   = 3'd3,
        FINISH = 3'd4
    } state_e;

endpackage

// File: rtl/gpio_serial_loader.sv
// Snapshots a flat pad configuration image and shifts it MSB-first through the GPIO
// control-block daisy chain, then strobes chain_load so every block latches its word.
module gpio_serial_loader
    import gpio_cfg_pkg::*;
#(
    parameter int NUM_GPIO      = 19,
    parameter int PAD_CTRL_BITS = gpio_cfg_pkg::PAD_CTRL_BITS,
    parameter int LOAD_CYC      = 2
) (
    input  logic                                serial_clock,
    input  logic                                resetn,
    input  logic                                start,
    input  logic [NUM_GPIO*PAD_CTRL_BITS-1:0]   cfg_data,
    output logic                                busy,
    output logic                                done,
    output logic                                chain_clock,
    output logic                                chain_data,
    output logic                                chain_load,
    output gpio_cfg_pkg::state_e                state
);

    localparam int TOTAL = NUM_GPIO * PAD_CTRL_BITS;
    localparam int CW    = $clog2(TOTAL);
    localparam logic [CW-1:0] LAST_BIT = CW'(TOTAL - 1);
    localparam logic [CW-1:0] HOLD_CNT = CW'(LOAD_CYC);

    // Handshake: start is a single-cycle request sampled only in IDLE, never while
    // done is high and never on the first edge after reset release; no queuing.
    logic [TOTAL-1:0] snapshot;
    logic [CW-1:0]    cnt;
    logic             armed;

    always_ff @(posedge serial_clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            snapshot    <= '0;
            cnt         <= '0;
            armed       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            chain_clock <= 1'b0;
            chain_data  <= 1'b0;
            chain_load  <= 1'b0;
        end else begin
            armed <= 1'b1;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && armed && !done) begin
                        snapshot <= cfg_data;
                        cnt      <= LAST_BIT;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    chain_clock <= 1'b0;
                    chain_data  <= snapshot[cnt];
                    state       <= HIGH;
                end
                HIGH: begin
                    chain_clock <= 1'b1;
                    if (cnt == '0) begin
                        // The bit counter doubles as the load-hold counter.
                        cnt   <= HOLD_CNT;
                        state <= LOAD;
                    end else begin
                        cnt   <= cnt - 1'b1;
                        state <= SETUP;
                    end
                end
                LOAD: begin
                    chain_clock <= 1'b0;
                    chain_data  <= 1'b0;
                    if (cnt == '0) begin
                        chain_load <= 1'b0;
                        state      <= FINISH;
                    end else begin
                        chain_load <= 1'b1;
                        cnt        <= cnt - 1'b1;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Bench for gpio_serial_loader on a two-block chain with behavioural control-block
// models; latched pad words are checked against a scoreboard of accepted images.
module tb_gpio_serial_loader;
    import gpio_cfg_pkg::*;

    localparam int NG  = 2;
    localparam int PB  = 10;
    localparam int LC  = 2;
    localparam int T   = NG * PB;
    localparam int LAT = 2 * T + LC + 2;
    localparam logic [PB-1:0] PAD_DEFAULT = PB'((1 << IE) | (1 << MGMT_EN));

    logic          serial_clock;
    logic          resetn;
    logic          start;
    logic [T-1:0]  cfg_data;
    logic          busy, done, chain_clock, chain_data, chain_load;
    state_e        state;

    gpio_serial_loader #(.NUM_GPIO(NG), .PAD_CTRL_BITS(PB), .LOAD_CYC(LC)) dut (
        .serial_clock(serial_clock),
        .resetn(resetn),
        .start(start),
        .cfg_data(cfg_data),
        .busy(busy),
        .done(done),
        .chain_clock(chain_clock),
        .chain_data(chain_data),
        .chain_load(chain_load),
        .state(state)
    );

    initial serial_clock = 1'b0;
    always #5 serial_clock = ~serial_clock;

    // Control blocks: block 0 is the chain head, block 1 shifts in block 0's MSB.
    logic [PB-1:0] blk_sr [NG];
    logic [PB-1:0] pad_latch [NG];

    always @(posedge chain_clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NG; k++) blk_sr[k] <= '0;
        end else begin
            blk_sr[0] <= {blk_sr[0][PB-2:0], chain_data};
            for (int k = 1; k < NG; k++) blk_sr[k] <= {blk_sr[k][PB-2:0], blk_sr[k-1][PB-1]};
        end
    end

    always @(posedge chain_load or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NG; k++) pad_latch[k] <= PAD_DEFAULT;
        end else begin
            for (int k = 0; k < NG; k++) pad_latch[k] <= blk_sr[k];
        end
    end

    int tests = 0;
    int fails = 0;
    logic [T-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input logic [T-1:0] cfg, input logic [T-1:0] cfg_after,
                            input int extra_a, input int extra_b,
                            input bit pre_hold, input bit quiet_after);
        int cyc, edges, loads, dones, lat;
        bit ok_busy, ok_overlap, ok_stable;
        logic prev_clk, prev_data;
        logic [T-1:0] exp;
        cfg_data = cfg;
        start    = 1'b1;
        exp_q.push_back(cfg);
        if (pre_hold) begin
            // This edge falls in the previous transfer's done cycle.
            @(negedge serial_clock);
            check("start_in_done_cycle_ignored", 32'(busy), 32'd0);
        end
        cyc = 0; edges = 0; loads = 0; dones = 0; lat = -1;
        ok_busy = 1; ok_overlap = 1; ok_stable = 1;
        prev_clk = chain_clock; prev_data = chain_data;
        while (dones == 0 && cyc < LAT + 20) begin
            @(negedge serial_clock);
            cyc++;
            start = (cyc == extra_a || cyc == extra_b);
            if (cyc == 1) cfg_data = cfg_after;
            if (chain_clock && !prev_clk) edges++;
            if (chain_load) loads++;
            if (chain_load && chain_clock) ok_overlap = 0;
            if (chain_clock && chain_data !== prev_data) ok_stable = 0;
            if (done) begin
                dones++;
                lat = cyc - 1;
                check("busy_low_in_done_cycle", 32'(busy), 32'd0);
            end else if (!busy) begin
                ok_busy = 0;
            end
            prev_clk  = chain_clock;
            prev_data = chain_data;
        end
        start = 1'b0;
        check("latency", 32'(lat), 32'(LAT));
        check("chain_clock_edges", 32'(edges), 32'(T));
        check("chain_load_cycles", 32'(loads), 32'(LC));
        check("busy_held", 32'(ok_busy), 32'd1);
        check("load_clock_overlap_free", 32'(ok_overlap), 32'd1);
        check("data_stable_while_clock_high", 32'(ok_stable), 32'd1);
        if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check("pad0_latch", 32'(pad_latch[0]), 32'(exp[PB-1:0]));
            check("pad1_latch", 32'(pad_latch[1]), 32'(exp[2*PB-1:PB]));
        end
        if (quiet_after) begin
            dones = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge serial_clock);
                if (done || busy || chain_clock) dones++;
            end
            check("quiet_after_done", 32'(dones), 32'd0);
        end
    endtask

    typedef struct {
        logic [T-1:0] cfg;
        logic [T-1:0] cfg_after;
        int           extra_a;
        int           extra_b;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int edges, loads, activity;
        logic [T-1:0] rnd;
        rnd = T'($urandom_range(0, (1 << T) - 1));
        vecs[0] = '{20'hA53C6, 20'hA53C6, -1, -1};
        vecs[1] = '{20'h12345, 20'h12345, 5, 30};
        vecs[2] = '{20'h3C0F5, 20'h00000, -1, -1};
        vecs[3] = '{20'h00001, 20'h80000, 5, 30};
        vecs[4] = '{rnd, ~rnd, 7, 41};

        resetn   = 1'b1;
        start    = 1'b0;
        cfg_data = '0;
        #1 resetn = 1'b0;
        repeat (3) @(negedge serial_clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_chain_clock", 32'(chain_clock), 32'd0);
        check("rst_chain_data", 32'(chain_data), 32'd0);
        check("rst_chain_load", 32'(chain_load), 32'd0);
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_pad0", 32'(pad_latch[0]), 32'(PAD_DEFAULT));
        check("rst_pad1", 32'(pad_latch[1]), 32'(PAD_DEFAULT));
        resetn = 1'b1;
        activity = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge serial_clock);
            if (chain_clock || busy || chain_load) activity++;
        end
        check("idle_no_activity", 32'(activity), 32'd0);

        for (int v = 0; v < 5; v++)
            run_xfer(vecs[v].cfg, vecs[v].cfg_after, vecs[v].extra_a, vecs[v].extra_b, 1'b0, 1'b1);

        // Abort in the middle of bit 7, then restart with start coinciding with release.
        cfg_data = 20'h5A5A5;
        start = 1'b1;
        edges = 0; loads = 0;
        for (int i = 0; i < 100 && edges < 7; i++) begin
            logic prev;
            prev = chain_clock;
            @(negedge serial_clock);
            start = 1'b0;
            if (chain_clock && !prev) edges++;
            if (chain_load) loads++;
        end
        check("abort_reached_bit7", 32'(edges), 32'd7);
        resetn = 1'b0;
        #1;
        check("abort_outputs_zero", 32'({busy, done, chain_clock, chain_data, chain_load}), 32'd0);
        check("abort_state_idle", 32'(state), 32'(IDLE));
        repeat (5) begin
            @(negedge serial_clock);
            if (chain_load) loads++;
        end
        check("abort_no_load", 32'(loads), 32'd0);
        check("abort_pad0_default", 32'(pad_latch[0]), 32'(PAD_DEFAULT));
        check("abort_pad1_default", 32'(pad_latch[1]), 32'(PAD_DEFAULT));
        resetn = 1'b1;
        start  = 1'b1;
        @(negedge serial_clock);
        start = 1'b0;
        check("start_at_release_ignored", 32'(busy), 32'd0);
        @(negedge serial_clock);
        run_xfer(20'h6B1D2, 20'h6B1D2, -1, -1, 1'b0, 1'b1);

        // Back-to-back: second request held across the done cycle.
        run_xfer(20'h0F0F0, 20'h0F0F0, -1, -1, 1'b0, 1'b0);
        run_xfer(20'hFFFFF, 20'hFFFFF, -1, -1, 1'b1, 1'b1);
        check("b2b_pad0_all_ones", 32'(pad_latch[0]), 32'h3FF);
        check("b2b_pad1_all_ones", 32'(pad_latch[1]), 32'h3FF);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
